// File: rtl/dmem_responder.sv
// Data-memory responder for a CPU memory stage: one outstanding access,
// configurable response latency, RV32I byte/half/word loads and stores
// on a little-endian word array with misalignment and range checking.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} StateT;

    StateT       stateQ;
    logic [3:0]  cntQ;
    logic        capWe;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [2:0]  capF3;
    logic        reqReadyQ;
    logic        rspValidQ;
    logic [31:0] rspRdataQ;
    logic        rspErrQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            fromIdle;
    logic            goResp;
    logic            selWe;
    logic [31:0]     selAddr;
    logic [31:0]     selWdata;
    logic [2:0]      selF3;
    logic [IdxW-1:0] wordIdx;
    logic [31:0]     rdWord;
    logic [31:0]     shifted;
    logic [7:0]      byteVal;
    logic [15:0]     halfVal;
    logic [31:0]     loadData;
    logic            accErr;
    logic [31:0]     accRdata;
    logic [3:0]      wrMask;
    logic [31:0]     wrData;
    logic [31:0]     merged;
    logic            memWe;

    assign req_ready = reqReadyQ;
    assign rsp_valid = rspValidQ;
    assign rsp_rdata = rspRdataQ;
    assign rsp_err   = rspErrQ;

    assign accept   = req_valid && reqReadyQ;
    assign fromIdle = (stateQ == StIdle);

    // With zero latency the access executes on the accept edge itself, so the
    // live request is used; otherwise the captured copy is used.
    assign selWe    = fromIdle ? req_we     : capWe;
    assign selAddr  = fromIdle ? req_addr   : capAddr;
    assign selWdata = fromIdle ? req_wdata  : capWdata;
    assign selF3    = fromIdle ? req_funct3 : capF3;

    assign goResp = (fromIdle && accept && (LATENCY == 0)) ||
                    ((stateQ == StWait) && (cntQ == 4'd1));

    assign wordIdx = selAddr[IdxW+1:2];
    assign rdWord  = mem[wordIdx];
    assign shifted = rdWord >> {selAddr[1:0], 3'b000};
    assign byteVal = shifted[7:0];
    assign halfVal = selAddr[1] ? rdWord[31:16] : rdWord[15:0];

    // Access legality: reserved codes, bad store sizes, misalignment, range.
    always_comb begin
        accErr = 1'b0;
        case (selF3)
            3'd3, 3'd6, 3'd7: accErr = 1'b1;
            default: ;
        endcase
        if (selWe && (selF3 > 3'd2)) accErr = 1'b1;
        if ((selF3[1:0] == 2'd1) && selAddr[0]) accErr = 1'b1;
        if ((selF3 == 3'd2) && (selAddr[1:0] != 2'd0)) accErr = 1'b1;
        if ({2'b00, selAddr[31:2]} >= DEPTH_WORDS) accErr = 1'b1;
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        loadData = 32'd0;
        case (selF3)
            3'd0: loadData = {{24{byteVal[7]}}, byteVal};
            3'd1: loadData = {{16{halfVal[15]}}, halfVal};
            3'd2: loadData = rdWord;
            3'd4: loadData = {24'd0, byteVal};
            3'd5: loadData = {16'd0, halfVal};
            default: loadData = 32'd0;
        endcase
    end

    assign accRdata = (accErr || selWe) ? 32'd0 : loadData;

    // Store lane replication and byte-enable mask, merged over the old word.
    always_comb begin
        wrMask = 4'b1111;
        wrData = selWdata;
        case (selF3[1:0])
            2'd0: begin
                wrData = {4{selWdata[7:0]}};
                wrMask = 4'b0001 << selAddr[1:0];
            end
            2'd1: begin
                wrData = {2{selWdata[15:0]}};
                wrMask = selAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wrData = selWdata;
                wrMask = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wrMask[i] ? wrData[8*i +: 8] : rdWord[8*i +: 8];
        end
    end

    // Write only on the edge entering RESP, so a held response never rewrites.
    assign memWe = goResp && selWe && !accErr && rst;

    // Backing storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (memWe) mem[wordIdx] <= merged;
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StIdle;
            cntQ      <= 4'd0;
            capWe     <= 1'b0;
            capAddr   <= 32'd0;
            capWdata  <= 32'd0;
            capF3     <= 3'd0;
            reqReadyQ <= 1'b0;
            rspValidQ <= 1'b0;
            rspRdataQ <= 32'd0;
            rspErrQ   <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    reqReadyQ <= 1'b1;
                    if (accept) begin
                        capWe     <= req_we;
                        capAddr   <= req_addr;
                        capWdata  <= req_wdata;
                        capF3     <= req_funct3;
                        reqReadyQ <= 1'b0;
                        if (LATENCY == 0) begin
                            stateQ    <= StResp;
                            rspValidQ <= 1'b1;
                            rspRdataQ <= accRdata;
                            rspErrQ   <= accErr;
                        end else begin
                            stateQ <= StWait;
                            cntQ   <= 4'(LATENCY);
                        end
                    end
                end
                StWait: begin
                    if (cntQ == 4'd1) begin
                        stateQ    <= StResp;
                        cntQ      <= 4'd0;
                        rspValidQ <= 1'b1;
                        rspRdataQ <= accRdata;
                        rspErrQ   <= accErr;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        stateQ    <= StIdle;
                        reqReadyQ <= 1'b1;
                        rspValidQ <= 1'b0;
                        rspRdataQ <= 32'd0;
                        rspErrQ   <= 1'b0;
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance A uses LATENCY=2 and the
// default depth, instance B uses LATENCY=0 with a 16-word array.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [2:0]  reqFunct3;

    logic        bReqValid, bReqReady, bReqWe, bRspValid, bRspReady, bRspErr;
    logic [31:0] bReqAddr, bReqWdata, bRspRdata;
    logic [2:0]  bReqFunct3;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqFunct3),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata), .rsp_err(rspErr)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(bReqValid), .req_ready(bReqReady), .req_we(bReqWe),
        .req_addr(bReqAddr), .req_wdata(bReqWdata), .req_funct3(bReqFunct3),
        .rsp_valid(bRspValid), .rsp_ready(bRspReady),
        .rsp_rdata(bRspRdata), .rsp_err(bRspErr)
    );

    int passed = 0;
    int total  = 0;

    logic [32:0] aQ[$];
    logic [32:0] bQ[$];
    logic [32:0] aExp, bExp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic noteFail(input string name);
        total++;
        $display("FAIL %s: got timeout/unexpected event expected handshake", name);
    endtask

    // Scoreboard monitors: pop on every response handshake.
    always @(negedge clk) begin
        if (rst && rspValid && rspReady) begin
            if (aQ.size() == 0) noteFail("a_unexpected_rsp");
            else begin
                aExp = aQ.pop_front();
                check("a_rsp_rdata", rspRdata, aExp[31:0]);
                check("a_rsp_err", {31'd0, rspErr}, {31'd0, aExp[32]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bRspValid && bRspReady) begin
            if (bQ.size() == 0) noteFail("b_unexpected_rsp");
            else begin
                bExp = bQ.pop_front();
                check("b_rsp_rdata", bRspRdata, bExp[31:0]);
                check("b_rsp_err", {31'd0, bRspErr}, {31'd0, bExp[32]});
            end
        end
    end

    task automatic aAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] expData,
                           input logic expErr, output int wc);
        bit acc;
        int n;
        aQ.push_back({expErr, expData});
        reqWe = we; reqAddr = addr; reqWdata = wdata; reqFunct3 = f3; reqValid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (reqReady) acc = 1; else n++;
        end
        if (!acc) noteFail("a_accept_timeout");
        @(posedge clk); #1 reqValid = 1'b0;
        acc = 0; wc = 0;
        while (!acc && wc < 50) begin
            @(negedge clk);
            if (rspValid) acc = 1; else wc++;
        end
        if (!acc) noteFail("a_rsp_timeout");
        @(posedge clk); #1;
    endtask

    task automatic bAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] expData,
                           input logic expErr, output int wc);
        bit acc;
        int n;
        bQ.push_back({expErr, expData});
        bReqWe = we; bReqAddr = addr; bReqWdata = wdata; bReqFunct3 = f3; bReqValid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (bReqReady) acc = 1; else n++;
        end
        if (!acc) noteFail("b_accept_timeout");
        @(posedge clk); #1 bReqValid = 1'b0;
        acc = 0; wc = 0;
        while (!acc && wc < 50) begin
            @(negedge clk);
            if (bRspValid) acc = 1; else wc++;
        end
        if (!acc) noteFail("b_rsp_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, acc, last;
        rst = 1'b0;
        reqValid = 0; reqWe = 0; reqAddr = 0; reqWdata = 0; reqFunct3 = 0; rspReady = 1'b1;
        bReqValid = 0; bReqWe = 0; bReqAddr = 0; bReqWdata = 0; bReqFunct3 = 0; bRspReady = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, reqReady}, 32'd0);
        check("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
        check("rst_rsp_rdata", rspRdata, 32'd0);
        check("rst_rsp_err", {31'd0, rspErr}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {31'd0, reqReady}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_edge", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;

        // Word store/load and latency.
        aAccess(1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0, wc);
        check("a_latency", wc, 32'd2);
        aAccess(0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0, wc);

        // Byte store into a cleared word; signed/unsigned byte loads.
        aAccess(1, 32'h10, 32'h0, 3'd2, 32'h0, 0, wc);
        aAccess(1, 32'h13, 32'h80, 3'd0, 32'h0, 0, wc);
        aAccess(0, 32'h13, 32'h0, 3'd0, 32'hFFFFFF80, 0, wc);
        aAccess(0, 32'h13, 32'h0, 3'd4, 32'h00000080, 0, wc);
        aAccess(0, 32'h10, 32'h0, 3'd2, 32'h80000000, 0, wc);

        // Errors leave memory untouched.
        aAccess(1, 32'h11, 32'h1234, 3'd1, 32'h0, 1, wc);
        aAccess(0, 32'h10, 32'h0, 3'd2, 32'h80000000, 0, wc);
        aAccess(0, 32'd4096, 32'h0, 3'd2, 32'h0, 1, wc);
        aAccess(0, 32'h10, 32'h0, 3'd3, 32'h0, 1, wc);
        aAccess(1, 32'h10, 32'h5, 3'd4, 32'h0, 1, wc);
        aAccess(0, 32'h11, 32'h0, 3'd2, 32'h0, 1, wc);

        // Halfword store in the upper lanes and half/byte loads.
        aAccess(1, 32'h12, 32'hBEEF, 3'd1, 32'h0, 0, wc);
        aAccess(0, 32'h12, 32'h0, 3'd1, 32'hFFFFBEEF, 0, wc);
        aAccess(0, 32'h12, 32'h0, 3'd5, 32'h0000BEEF, 0, wc);
        aAccess(0, 32'h10, 32'h0, 3'd2, 32'hBEEF0000, 0, wc);
        aAccess(0, 32'h12, 32'h0, 3'd0, 32'hFFFFFFEF, 0, wc);
        aAccess(1, 32'h20, 32'h11223344, 3'd2, 32'h0, 0, wc);
        aAccess(0, 32'h21, 32'h0, 3'd4, 32'h00000033, 0, wc);
        aAccess(0, 32'h20, 32'h0, 3'd5, 32'h00003344, 0, wc);

        // Back-pressure: response held stable while rsp_ready is low.
        rspReady = 1'b0;
        aAccess(0, 32'h20, 32'h0, 3'd2, 32'h11223344, 0, wc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", {31'd0, rspValid}, 32'd1);
            check("stall_rsp_rdata", rspRdata, 32'h11223344);
            check("stall_req_ready", {31'd0, reqReady}, 32'd0);
        end
        @(posedge clk); #1 rspReady = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_req_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;

        // Reset mid-WAIT discards the pending store.
        reqWe = 1; reqAddr = 32'h20; reqWdata = 32'h55; reqFunct3 = 3'd2; reqValid = 1'b1;
        @(negedge clk);
        check("rst_test_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1 reqValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, reqReady}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rspValid}, 32'd0);
        check("midrst_rsp_rdata", rspRdata, 32'd0);
        check("midrst_rsp_err", {31'd0, rspErr}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        aAccess(0, 32'h20, 32'h0, 3'd2, 32'h11223344, 0, wc);

        // Zero-latency instance: response right after accept, one access per 2 cycles.
        bAccess(1, 32'h4, 32'h0000A5A5, 3'd2, 32'h0, 0, wc);
        check("b_latency", wc, 32'd0);
        bAccess(0, 32'h40, 32'h0, 3'd2, 32'h0, 1, wc);
        bReqWe = 0; bReqAddr = 32'h4; bReqFunct3 = 3'd2; bReqValid = 1'b1;
        acc = 0; last = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bReqReady) begin
                bQ.push_back({1'b0, 32'h0000A5A5});
                acc++;
                if (last >= 0) check("b_accept_gap", i - last, 32'd2);
                last = i;
            end
        end
        @(posedge clk); #1 bReqValid = 1'b0;
        check("b_accept_count", acc, 32'd10);

        repeat (5) @(posedge clk);
        #1;
        check("a_queue_drained", aQ.size(), 32'd0);
        check("b_queue_drained", bQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001: Parameter DEPTH_WORDS, default 1024, number of 32-bit words of backing storage (power of two, >= 4).
REQ-002: Parameter LATENCY, default 2, wait cycles inserted between request acceptance and response (0..15).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005: req_valid  input  1  CPU memory-stage access request present.
REQ-006: req_ready  output  1  responder can accept a request this cycle.
REQ-007: req_we  input  1  1 = store, 0 = load.
REQ-008: req_addr  input  32  byte address.
REQ-009: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010: req_funct3  input  3  RV32I access size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011: rsp_valid  output  1  response present.
REQ-012: rsp_ready  input  1  CPU accepts the response.
REQ-013: rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014: rsp_err  output  1  access was rejected (misaligned, out of range, illegal funct3).

Function
REQ-015: One outstanding access; FSM states IDLE, WAIT, RESP.
REQ-016: req_ready = 1 only in IDLE; accept = req_valid && req_ready; on accept capture we/addr/wdata/funct3.
REQ-017: Accept with LATENCY = 0 -> RESP next cycle; LATENCY > 0 -> WAIT with counter loaded to LATENCY.
REQ-018: WAIT decrements counter each cycle; moves to RESP on the cycle counter reaches 1 (rsp_valid first high LATENCY+1 cycles after accept edge).
REQ-019: On entry to RESP: error check, memory read/write, rsp_rdata/rsp_err registered; values held stable while rsp_valid = 1.
REQ-020: RESP: rsp_valid = 1; rsp_ready = 1 -> IDLE next cycle (req_ready high that cycle); rsp_ready = 0 -> stay.
REQ-021: Request arriving in WAIT/RESP is ignored (req_ready = 0); CPU must hold it.
REQ-022: Error: funct3 in {3,6,7}; store funct3 not in {0,1,2}; half access with addr[0] = 1; word access with addr[1:0] != 0; word index addr[31:2] >= DEPTH_WORDS.
REQ-023: On error: no memory write, rsp_rdata = 0, rsp_err = 1; otherwise rsp_err = 0.
REQ-024: SB writes only byte lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all four; other lanes unchanged.
REQ-025: Loads select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-026: Store is committed exactly once, at the RESP-entry edge; holding RESP does not re-write.
REQ-027: Storage is little-endian; load immediately after a store to the same address returns the stored data.

Reset
REQ-028: rst = 0 asynchronously forces IDLE, counter 0, req_ready = 0 while asserted, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029: req_ready = 1 from the first clock edge after rst deasserts.
REQ-030: Storage contents are not reset; reset during WAIT discards the access with no write; reset in RESP leaves the already-committed write in place.

Verification
REQ-031: LATENCY=2: SW 0xDEADBEEF @0x10, rsp_ready=1 -> rsp_valid on 3rd edge after accept, rsp_err=0; LW @0x10 -> rsp_rdata=0xDEADBEEF.
REQ-032: SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-033: SH 0x1234 @0x11 -> rsp_err=1, rsp_rdata=0; LW @0x10 unchanged; LW @0x4*DEPTH_WORDS -> rsp_err=1.
REQ-034: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, single write; release -> req_ready=1 next cycle.
REQ-035: LATENCY=0: back-to-back LW with rsp_ready=1 -> one access accepted every 2 cycles.
REQ-036: rst=0 mid-WAIT of SW 0x55 @0x20 -> outputs 0 immediately; after release LW @0x20 returns prior value.
